// File: rtl/fifo_status_gen.sv
// FIFO status monitor: full/empty decode, fill level, threshold flags, sticky error flags and counters.
// Latency: full/empty are combinational; every other output is registered with 1-cycle latency.
// Backpressure: none. The block only observes pointers and handshakes. Define FIFO_STATUS_PEAK_EN to enable the peak_level tracker.
module fifo_status_gen #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   wptr,
  input  logic [ADDR_W:0]   rptr,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   afull_thr,
  input  logic [ADDR_W:0]   aempty_thr,
  input  logic              clr_ovf,
  input  logic              clr_udf,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  output logic [CNT_W-1:0]  ovf_cnt,
  output logic [CNT_W-1:0]  udf_cnt,
  output logic [ADDR_W:0]   peak_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              low_eq;
  logic [ADDR_W:0]   diff;
  logic              ovf_evt;
  logic              udf_evt;
  logic [CNT_W-1:0]  ovf_cnt_nxt;
  logic [CNT_W-1:0]  udf_cnt_nxt;

  // Pointer decode: the wrap bit separates full from empty when the low bits match.
  assign low_eq = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign empty  = (wptr[ADDR_W] == rptr[ADDR_W]) & low_eq;
  assign full   = (wptr[ADDR_W] != rptr[ADDR_W]) & low_eq;

  // Modular subtraction gives the occupancy directly, including across pointer wrap.
  assign diff = wptr - rptr;

  assign ovf_evt = full  & wr_req & ~rd_en;
  assign udf_evt = empty & rd_req & ~wr_en;

  // Next counter values: clear wins over hold, an event in the clear cycle counts as one, and counting saturates.
  always_comb begin
    ovf_cnt_nxt = ovf_cnt;
    udf_cnt_nxt = udf_cnt;
    if (clr_ovf)
      ovf_cnt_nxt = ovf_evt ? CNT_W'(1) : '0;
    else if (ovf_evt && ovf_cnt != CNT_MAX)
      ovf_cnt_nxt = ovf_cnt + CNT_W'(1);
    if (clr_udf)
      udf_cnt_nxt = udf_evt ? CNT_W'(1) : '0;
    else if (udf_evt && udf_cnt != CNT_MAX)
      udf_cnt_nxt = udf_cnt + CNT_W'(1);
  end

  // Level and threshold flags track the pointers one cycle late; thresholds are sampled each edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      level        <= diff;
      almost_full  <= (diff >= afull_thr);
      almost_empty <= (diff <= aempty_thr);
    end
  end

  // Sticky error flags: a new event beats a clear; a real read/write of the opposite kind also clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt)
        overflow <= 1'b1;
      else if (clr_ovf | rd_en)
        overflow <= 1'b0;
      if (udf_evt)
        underflow <= 1'b1;
      else if (clr_udf | wr_en)
        underflow <= 1'b0;
    end
  end

  // Event counters are only cleared by software, never by traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else begin
      ovf_cnt <= ovf_cnt_nxt;
      udf_cnt <= udf_cnt_nxt;
    end
  end

`ifdef FIFO_STATUS_PEAK_EN
  // High-water mark; clearing both error classes together re-arms it from the current occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      peak_level <= '0;
    else if (clr_ovf & clr_udf)
      peak_level <= diff;
    else if (diff > peak_level)
      peak_level <= diff;
  end
`else
  assign peak_level = '0;
`endif

endmodule
